// File: rtl/fmps_pkg.sv
// Shared definitions for the FMPS readout RAM arbitration logic:
// requester IDs, default geometry, counter width and small helpers.
package fmps_pkg;

  // Requester ID carried through the read pipeline.
  typedef logic fmps_req_id_t;

  localparam fmps_req_id_t FMPS_REQ_A = 1'b0;  // streaming readout engine
  localparam fmps_req_id_t FMPS_REQ_B = 1'b1;  // host CSR readback path

  // Default RAM address width (32 FMPS entries).
  localparam int FMPS_INDEX_WIDTH = 5;

  // Width of the contention counter.
  localparam int CONFLICT_COUNT_WIDTH = 16;

  // One slot of the read pipeline: a valid bit plus the owner of the read.
  typedef struct packed {
    logic         valid;
    fmps_req_id_t id;
  } fmps_pipe_stage_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CONFLICT_COUNT_WIDTH-1:0] fmps_sat_inc(
    input logic [CONFLICT_COUNT_WIDTH-1:0] value
  );
    if (&value) begin
      return value;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/fmps_read_pipe.sv
// Read return path for the FMPS readout RAM. Carries the valid bit and
// requester ID of each granted read across the address and data stages,
// then captures the RAM word into the owning requester's response register.
// The non-owning requester's data register keeps its previous value.
module fmps_read_pipe
  import fmps_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sysClk,
  input  logic                  sysReset,
  input  logic                  issue_valid,  // read granted this cycle
  input  fmps_req_id_t          issue_id,     // owner of the granted read
  input  logic [DATA_WIDTH-1:0] mem_data,     // RAM word, aligned with stage 2
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_data
);

  // stage1 lines up with the registered RAM address,
  // stage2 lines up with the RAM read data.
  fmps_pipe_stage_t stage1;
  fmps_pipe_stage_t stage2;

  logic a_hit;
  logic b_hit;

  // Decode which requester owns the word currently on mem_data.
  always_comb begin
    a_hit = stage2.valid && (stage2.id == FMPS_REQ_A);
    b_hit = stage2.valid && (stage2.id == FMPS_REQ_B);
  end

  // Valid/ID delay line; reset drops every read still in flight.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1.valid <= issue_valid;
      stage1.id    <= issue_id;
      stage2       <= stage1;
    end
  end

  // Response registers for requester A: pulse valid, capture data on hit.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      a_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
    end else begin
      a_rsp_valid <= a_hit;
      if (a_hit) begin
        a_rsp_data <= mem_data;
      end
    end
  end

  // Response registers for requester B: pulse valid, capture data on hit.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      b_rsp_valid <= 1'b0;
      b_rsp_data  <= '0;
    end else begin
      b_rsp_valid <= b_hit;
      if (b_hit) begin
        b_rsp_data <= mem_data;
      end
    end
  end

endmodule

// File: rtl/fmps_readout_arbiter.sv
// Shares the single read port of the FMPS readout RAM between the streaming
// readout engine (A) and the host CSR readback path (B). One read is granted
// per cycle with round-robin tie breaking; each returned word is routed back
// to the requester that issued it, three cycles after the grant.
//
// Handshake (both request ports): a request transfers in the cycle where
// xReqValid && xReqReady are both high. Once raised, xReqValid must stay high
// with xReqAddress stable until xReqReady is seen. xReqReady depends
// combinationally on both Valid inputs and the registered last_grant pointer,
// never on the responses. Responses carry no back-pressure: xRspValid is a
// one-cycle pulse and xRspData is held until the next response for that port.
module fmps_readout_arbiter
  import fmps_pkg::*;
#(
  parameter int INDEX_WIDTH = FMPS_INDEX_WIDTH,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                            sysClk,
  input  logic                            sysReset,
  // Requester A: streaming readout engine
  input  logic                            aReqValid,
  input  logic [INDEX_WIDTH-1:0]          aReqAddress,
  output logic                            aReqReady,
  output logic                            aRspValid,
  output logic [DATA_WIDTH-1:0]           aRspData,
  // Requester B: host CSR readback path
  input  logic                            bReqValid,
  input  logic [INDEX_WIDTH-1:0]          bReqAddress,
  output logic                            bReqReady,
  output logic                            bRspValid,
  output logic [DATA_WIDTH-1:0]           bRspData,
  // RAM read port
  output logic [INDEX_WIDTH-1:0]          memAddress,
  input  logic [DATA_WIDTH-1:0]           memData,
  // Contention statistics
  output logic [CONFLICT_COUNT_WIDTH-1:0] conflictCount
);

  fmps_req_id_t           last_grant;     // owner of the most recent transfer
  logic                   a_grant;
  logic                   b_grant;
  logic                   any_grant;
  logic                   both_valid;
  fmps_req_id_t           grant_id;
  logic [INDEX_WIDTH-1:0] grant_address;

  // Round-robin grant: a lone requester always wins; on a tie the requester
  // that did not win last time goes. Nothing is granted while in reset.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (!sysReset) begin
      if (aReqValid && bReqValid) begin
        a_grant = (last_grant == FMPS_REQ_B);
        b_grant = (last_grant == FMPS_REQ_A);
      end else begin
        a_grant = aReqValid;
        b_grant = bReqValid;
      end
    end
  end

  // Select the owner and address of this cycle's transfer.
  always_comb begin
    both_valid    = aReqValid && bReqValid;
    any_grant     = a_grant || b_grant;
    grant_id      = b_grant ? FMPS_REQ_B : FMPS_REQ_A;
    grant_address = b_grant ? bReqAddress : aReqAddress;
  end

  assign aReqReady = a_grant;
  assign bReqReady = b_grant;

  // Round-robin pointer; starts at B so that A wins the first tie.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      last_grant <= FMPS_REQ_B;
    end else if (any_grant) begin
      last_grant <= grant_id;
    end
  end

  // Registered RAM address; holds its value on idle cycles since the RAM
  // read has no side effects and needs no enable.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      memAddress <= '0;
    end else if (any_grant) begin
      memAddress <= grant_address;
    end
  end

  // Count cycles with both requesters asking, sticking at all-ones.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      conflictCount <= '0;
    end else if (both_valid) begin
      conflictCount <= fmps_sat_inc(conflictCount);
    end
  end

  fmps_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_read_pipe (
    .sysClk      (sysClk),
    .sysReset    (sysReset),
    .issue_valid (any_grant),
    .issue_id    (grant_id),
    .mem_data    (memData),
    .a_rsp_valid (aRspValid),
    .a_rsp_data  (aRspData),
    .b_rsp_valid (bRspValid),
    .b_rsp_data  (bRspData)
  );

endmodule

// File: tb/tb_fmps_readout_arbiter.sv
// Bench for fmps_readout_arbiter: a synchronous RAM model, a table of
// per-cycle request vectors with hand-computed Ready values, per-port
// expected-response queues tagged with their due cycle, and hand-written
// sequences for reset, max address and counter saturation.
module tb_fmps_readout_arbiter;

  localparam int IW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          sysClk = 1'b0;
  logic          sysReset;
  logic          aReqValid, bReqValid;
  logic [IW-1:0] aReqAddress, bReqAddress;
  logic          aReqReady, bReqReady;
  logic          aRspValid, bRspValid;
  logic [DW-1:0] aRspData, bRspData;
  logic [IW-1:0] memAddress;
  logic [DW-1:0] memData;
  logic [15:0]   conflictCount;

  always #5 sysClk = ~sysClk;

  fmps_readout_arbiter #(
    .INDEX_WIDTH (IW),
    .DATA_WIDTH  (DW)
  ) dut (
    .sysClk        (sysClk),
    .sysReset      (sysReset),
    .aReqValid     (aReqValid),
    .aReqAddress   (aReqAddress),
    .aReqReady     (aReqReady),
    .aRspValid     (aRspValid),
    .aRspData      (aRspData),
    .bReqValid     (bReqValid),
    .bReqAddress   (bReqAddress),
    .bReqReady     (bReqReady),
    .bRspValid     (bRspValid),
    .bRspData      (bRspData),
    .memAddress    (memAddress),
    .memData       (memData),
    .conflictCount (conflictCount)
  );

  // RAM model: one-cycle synchronous read.
  logic [DW-1:0] ram [32];
  always @(posedge sysClk) memData <= ram[memAddress];

  // ---------------- vector table ----------------
  typedef struct {
    logic          a_v;
    logic [IW-1:0] a_addr;
    logic          b_v;
    logic [IW-1:0] b_addr;
    logic          exp_a_rdy;
    logic          exp_b_rdy;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  // Each entry: {due cycle[63:32], expected data[31:0]}
  logic [63:0]   a_exp_q[$];
  logic [63:0]   b_exp_q[$];
  logic [DW-1:0] a_last;
  logic [DW-1:0] b_last;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_vec(input logic a_v, input int a_addr, input logic b_v, input int b_addr,
                         input logic ea, input logic eb);
    vec_t v;
    v.a_v = a_v; v.a_addr = IW'(a_addr);
    v.b_v = b_v; v.b_addr = IW'(b_addr);
    v.exp_a_rdy = ea; v.exp_b_rdy = eb;
    vecs.push_back(v);
  endtask

  task automatic push_a(input logic [IW-1:0] addr);
    a_exp_q.push_back({32'(cyc + 3), ram[addr]});
  endtask

  task automatic push_b(input logic [IW-1:0] addr);
    b_exp_q.push_back({32'(cyc + 3), ram[addr]});
  endtask

  // Compare this cycle's responses against the queues.
  task automatic check_rsp();
    logic [63:0] e;
    if (aRspValid) begin
      if (a_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_rsp_unexpected: got data %0h expected no response (cycle %0d)", aRspData, cyc);
      end else begin
        e = a_exp_q.pop_front();
        check("a_rsp_cycle", 64'(cyc), 64'(e[63:32]));
        check("a_rsp_data", 64'(aRspData), 64'(e[31:0]));
      end
      a_last = aRspData;
    end else begin
      check("a_rsp_hold", 64'(aRspData), 64'(a_last));
      if (a_exp_q.size() != 0 && a_exp_q[0][63:32] <= 32'(cyc)) begin
        checks++; errors++;
        e = a_exp_q.pop_front();
        $display("FAIL a_rsp_missing: got no response expected %0h due %0d (cycle %0d)", e[31:0], e[63:32], cyc);
      end
    end
    if (bRspValid) begin
      if (b_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_rsp_unexpected: got data %0h expected no response (cycle %0d)", bRspData, cyc);
      end else begin
        e = b_exp_q.pop_front();
        check("b_rsp_cycle", 64'(cyc), 64'(e[63:32]));
        check("b_rsp_data", 64'(bRspData), 64'(e[31:0]));
      end
      b_last = bRspData;
    end else begin
      check("b_rsp_hold", 64'(bRspData), 64'(b_last));
      if (b_exp_q.size() != 0 && b_exp_q[0][63:32] <= 32'(cyc)) begin
        checks++; errors++;
        e = b_exp_q.pop_front();
        $display("FAIL b_rsp_missing: got no response expected %0h due %0d (cycle %0d)", e[31:0], e[63:32], cyc);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are driven at the falling edge, outputs
  // sampled at the next falling edge.
  task automatic step();
    @(posedge sysClk);
    cyc++;
    @(negedge sysClk);
    check_rsp();
  endtask

  task automatic drive(input logic av, input logic [IW-1:0] aa, input logic bv, input logic [IW-1:0] ba);
    aReqValid = av; aReqAddress = aa;
    bReqValid = bv; bReqAddress = ba;
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v.a_v, v.a_addr, v.b_v, v.b_addr);
    #1;
    check("a_req_ready", 64'(aReqReady), 64'(v.exp_a_rdy));
    check("b_req_ready", 64'(bReqReady), 64'(v.exp_b_rdy));
    if (v.exp_a_rdy) push_a(v.a_addr);
    if (v.exp_b_rdy) push_b(v.b_addr);
    step();
    if (v.exp_a_rdy) check("mem_address_a", 64'(memAddress), 64'(v.a_addr));
    if (v.exp_b_rdy) check("mem_address_b", 64'(memAddress), 64'(v.b_addr));
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, '0);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset(input int n);
    drive(1'b0, '0, 1'b0, '0);
    sysReset = 1'b1;
    a_exp_q.delete();
    b_exp_q.delete();
    a_last = '0;
    b_last = '0;
    for (int k = 0; k < n; k++) step();
    sysReset = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_1011);

    // Table: A alone streams 0..31, idle, B alone, then 8 contended cycles
    // (B was last granted, so A, B, A, B, ...), then idle.
    for (int i = 0; i < 32; i++) add_vec(1'b1, i, 1'b0, 0, 1'b1, 1'b0);
    add_vec(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    add_vec(1'b0, 0, 1'b1, 9, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) add_vec(1'b1, 3, 1'b1, 17, (i % 2) == 0, (i % 2) == 1);
    add_vec(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Reset with both requesters asserting: Ready must stay low.
    a_last = '0;
    b_last = '0;
    sysReset = 1'b1;
    drive(1'b1, 5'd1, 1'b1, 5'd2);
    step();
    #1;
    check("rst_a_ready", 64'(aReqReady), 64'(0));
    check("rst_b_ready", 64'(bReqReady), 64'(0));
    step();
    check("rst_mem_address", 64'(memAddress), 64'(0));
    check("rst_conflict", 64'(conflictCount), 64'(0));
    check("rst_a_rsp_valid", 64'(aRspValid), 64'(0));
    check("rst_b_rsp_valid", 64'(bRspValid), 64'(0));
    drive(1'b0, '0, 1'b0, '0);
    sysReset = 1'b0;
    step();

    foreach (vecs[i]) apply_vec(vecs[i]);
    check("conflict_after_table", 64'(conflictCount), 64'(8));
    idle(5);

    // Three accepted A reads, then reset in the following cycle: only the
    // response already on the outputs is seen; later ones must vanish.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, IW'(5 + i), 1'b0, '0);
      #1;
      check("pre_rst_a_ready", 64'(aReqReady), 64'(1));
      push_a(IW'(5 + i));
      step();
    end
    do_reset(1);
    check("midrst_mem_address", 64'(memAddress), 64'(0));
    check("midrst_conflict", 64'(conflictCount), 64'(0));
    check("midrst_a_data", 64'(aRspData), 64'(0));
    idle(4);

    // First tie after reset goes to A; B holds and wins the next cycle.
    drive(1'b1, 5'd4, 1'b1, 5'd20);
    #1;
    check("tie_after_rst_a", 64'(aReqReady), 64'(1));
    check("tie_after_rst_b", 64'(bReqReady), 64'(0));
    push_a(5'd4);
    step();
    drive(1'b0, '0, 1'b1, 5'd20);
    #1;
    check("b_held_ready", 64'(bReqReady), 64'(1));
    push_b(5'd20);
    step();
    check("b_held_mem_address", 64'(memAddress), 64'(20));
    idle(5);

    // Maximum address from B while A idles.
    drive(1'b0, '0, 1'b1, 5'd31);
    #1;
    check("max_b_ready", 64'(bReqReady), 64'(1));
    push_b(5'd31);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("max_mem_address", 64'(memAddress), 64'(31));
    idle(4);

    // Continuous contention past the counter's range.
    do_reset(2);
    drive(1'b1, 5'd3, 1'b1, 5'd17);
    for (int k = 1; k <= 70000; k++) begin
      if ((k % 2) == 1) push_a(5'd3);
      else              push_b(5'd17);
      step();
      if (k == 65534) check("conflict_near_sat", 64'(conflictCount), 64'(16'hFFFE));
      if (k == 65535) check("conflict_at_sat", 64'(conflictCount), 64'(16'hFFFF));
    end
    check("conflict_saturated", 64'(conflictCount), 64'(16'hFFFF));
    idle(6);

    check("a_queue_drained", 64'(a_exp_q.size()), 64'(0));
    check("b_queue_drained", 64'(b_exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmps_readout_arbiter.md
# fmps_readout_arbiter

Two-port arbiter that shares the single FMPS readout RAM read port between the streaming readout engine (requester A) and the host CSR readback path (requester B). It sits between both requesters and the RAM address/data pins. It grants one read per cycle using round-robin selection, pipelines the RAM's 1-cycle read latency, and routes each returned word back to the requester that issued it.

## Interface
Parameters:
- `INDEX_WIDTH`, 5: RAM address width (2^INDEX_WIDTH FMPS entries).
- `DATA_WIDTH`, 32: readout word width.

Ports:
- `sysClk`  in  1: single clock for all logic.
- `sysReset`  in  1: synchronous, active-high reset.
- `aReqValid`  in  1: stream engine read request.
- `aReqAddress`  in  INDEX_WIDTH: stream engine read address.
- `aReqReady`  out  1: A request accepted this cycle.
- `aRspValid`  out  1: A read data valid, 1-cycle pulse.
- `aRspData`  out  DATA_WIDTH: A read data.
- `bReqValid`, `bReqAddress`, `bReqReady`, `bRspValid`, `bRspData`: same as the A ports, for the host path.
- `memAddress`  out  INDEX_WIDTH: RAM read address, registered.
- `memData`  in  DATA_WIDTH: RAM read data, valid 1 cycle after `memAddress`.
- `conflictCount`  out  16: saturating count of cycles where both requesters were valid.

## Operation
- Handshake:
  - A request transfers when Valid && Ready in the same cycle.
  - Valid must hold, with the address stable, until Ready is seen.
- `xReqReady` is combinational from the Valid inputs and the registered `lastGrant` pointer:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to `lastGrant` wins.
- `lastGrant` updates to the granted requester on every transfer and is unchanged on idle cycles.
- At most one transfer per cycle. Both Ready outputs are never high in the same cycle.
- On transfer, the granted address is registered into `memAddress`. A 2-stage pipeline carries valid and requester-ID bits alongside it.
- Stage 2 captures `memData` into the granted requester's `xRspData` and pulses its `xRspValid`.
- The other requester's `RspData` holds its previous value.
- `memAddress` holds its last value when idle. No read-enable is needed.
- `conflictCount` increments on each cycle with `aReqValid && bReqValid`. It saturates at 0xFFFF and clears only on reset.
- Responses are returned strictly in grant order. No response is ever dropped or duplicated.

## Timing
- Transfer in cycle N:
  - `memAddress` is valid in N+1.
  - `memData` is valid in N+2.
  - `xRspValid`/`xRspData` are registered and high in N+3.
  - Fixed latency is 3 cycles.
- Fully pipelined: back-to-back transfers every cycle give back-to-back responses.
- Alternating A/B grants under continuous contention give alternating responses.
- Reset values:
  - `memAddress`=0, `aRspValid`=`bRspValid`=0, `aRspData`=`bRspData`=0.
  - `conflictCount`=0.
  - `lastGrant`=B, so A wins the first tie.
  - Pipeline valid bits=0.
- Reset mid-operation clears all in-flight pipeline valid bits. No response is emitted for requests accepted before reset.
- Ready outputs are forced low while `sysReset` is high.
- Boundary behaviour:
  - Address 2^INDEX_WIDTH-1 is passed unchanged; there is no wrap logic in the arbiter.
  - Simultaneous request and response for the same requester is legal.

## Structure
- Shared package `fmps_pkg`:
  - Requester-ID encoding (`FMPS_REQ_A`=0, `FMPS_REQ_B`=1).
  - Default `INDEX_WIDTH`.
  - `CONFLICT_COUNT_WIDTH`=16.
- Sub-module `fmps_read_pipe`: 2-stage valid/ID delay line plus output data capture and demux. Parameterised on `DATA_WIDTH`.
- Top level holds the round-robin grant logic, the `memAddress` register and the conflict counter.

## Test plan
- Reset release, A alone requests addresses 0..31 back-to-back:
  - Ready is high every cycle.
  - `aRspValid` is high for 32 consecutive cycles starting 3 cycles after the first transfer.
  - `aRspData` equals RAM[0..31] in order.
  - B never responds.
- A and B both continuously valid (A addr 3, B addr 17) for 8 cycles:
  - Grants are A,B,A,B,… starting with A.
  - Responses alternate RAM[3]/RAM[17].
  - `conflictCount`=8.
- B valid alone for one cycle, then A and B valid together: B was `lastGrant`, so A is granted. B's request holds and is granted on the following cycle.
- Assert `sysReset` 1 cycle after three accepted requests:
  - No `RspValid` pulses follow.
  - All outputs return to their reset values.
  - The next tie goes to A.
- Force both valid for 70000 cycles: `conflictCount` saturates at 0xFFFF and does not wrap.
- Request address 31 (max) from B while A is idle: `memAddress`=31 in N+1, and `bRspData`=RAM[31] in N+3.
